// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared constants and types for the common data bus (CDB) arbiter.
//   CDB_ROB_ID_W   : default ROB id width
//   CDB_SRC_IDX_W  : width of the broadcast source index
//   CDB_SRC_*      : producer index constants (ALU, LSB, BRU)
//   cdb_entry_t    : one CDB entry, {rob_id, val}
//   rr_next()      : round-robin successor of a source index
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int CDB_ROB_ID_W  = 5;
    localparam int CDB_VAL_W     = 32;
    localparam int CDB_SRC_IDX_W = 2;

    localparam logic [CDB_SRC_IDX_W-1:0] CDB_SRC_ALU = 2'd0;
    localparam logic [CDB_SRC_IDX_W-1:0] CDB_SRC_LSB = 2'd1;
    localparam logic [CDB_SRC_IDX_W-1:0] CDB_SRC_BRU = 2'd2;

    typedef struct packed {
        logic [CDB_ROB_ID_W-1:0] rob_id;
        logic [CDB_VAL_W-1:0]    val;
    } cdb_entry_t;

    localparam int CDB_ENTRY_W = $bits(cdb_entry_t);

    // Next index after idx in a ring of n sources.
    function automatic logic [CDB_SRC_IDX_W-1:0] rr_next(
        input logic [CDB_SRC_IDX_W-1:0] idx,
        input int unsigned              n
    );
        if (32'(idx) >= (n - 32'd1)) begin
            return 2'd0;
        end else begin
            return idx + 2'd1;
        end
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// -----------------------------------------------------------------------------
// cdb_src_fifo
// Small per-producer FIFO feeding the CDB arbiter.
//   i_clk   : clock
//   i_flush : synchronous empty (reset or mispredict flush)
//   i_push  : write i_data at the tail (ignored when full)
//   i_pop   : drop the head entry (ignored when empty)
//   i_data  : entry to write
//   o_empty : no entries stored
//   o_full  : DEPTH entries stored
//   o_head  : oldest stored entry (valid only when !o_empty)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = CDB_ENTRY_W
) (
    input  logic             i_clk,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == {CNT_W{1'b0}});
    assign o_full  = (r_count == CNT_W'(DEPTH));
    // A full FIFO refuses the push even if it pops in the same cycle.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1'b1);
                2'b01:   r_count <= r_count - CNT_W'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter sharing the common data bus among result producers
// (0=ALU, 1=LSB, 2=BRU). Each producer has its own FIFO; one head entry is
// broadcast per cycle through registered outputs.
//   clk_in      : clock
//   rst_in      : synchronous active-high reset
//   rdy_in      : global enable, all state holds while low
//   clear_flag  : mispredict flush, same effect as reset, ignores rdy_in
//   src_valid   : per-producer push request
//   src_rob_id  : flattened ROB ids, source i at [i*ROB_ID_W +: ROB_ID_W]
//   src_val     : flattened values, source i at [i*32 +: 32]
//   src_ready   : FIFO i has room this cycle
//   cdb_valid   : one-cycle pulse per broadcast result
//   cdb_rob_id  : broadcast ROB id
//   cdb_val     : broadcast value
//   cdb_src     : index of the producer that was granted
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_ID_W   = CDB_ROB_ID_W
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        clear_flag,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*ROB_ID_W-1:0] src_rob_id,
    input  logic [NUM_SRC*32-1:0]       src_val,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic                        cdb_valid,
    output logic [ROB_ID_W-1:0]         cdb_rob_id,
    output logic [31:0]                 cdb_val,
    output logic [1:0]                  cdb_src
);

    localparam int ENTRY_W = ROB_ID_W + 32;

    logic                     w_flush;
    logic [NUM_SRC-1:0]       w_empty;
    logic [NUM_SRC-1:0]       w_full;
    logic [NUM_SRC-1:0]       w_push;
    logic [NUM_SRC-1:0]       w_pop;
    logic [ENTRY_W-1:0]       w_head [NUM_SRC];
    logic                     w_grant_valid;
    logic [1:0]               w_grant_idx;
    logic [ENTRY_W-1:0]       w_win_entry;

    logic [1:0]               r_rr_ptr;
    logic                     r_cdb_valid;
    logic [ROB_ID_W-1:0]      r_cdb_rob_id;
    logic [31:0]              r_cdb_val;
    logic [1:0]               r_cdb_src;

    assign w_flush   = rst_in | clear_flag;
    assign src_ready = ~w_full;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [ENTRY_W-1:0] w_entry;

        assign w_entry    = {src_rob_id[gi*ROB_ID_W +: ROB_ID_W], src_val[gi*32 +: 32]};
        assign w_push[gi] = rdy_in & src_valid[gi] & ~w_full[gi];
        assign w_pop[gi]  = rdy_in & w_grant_valid & (w_grant_idx == 2'(gi));

        cdb_src_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .i_clk   (clk_in),
            .i_flush (w_flush),
            .i_push  (w_push[gi]),
            .i_pop   (w_pop[gi]),
            .i_data  (w_entry),
            .o_empty (w_empty[gi]),
            .o_full  (w_full[gi]),
            .o_head  (w_head[gi])
        );
    end

    // Round-robin grant: scan rr_ptr..NUM_SRC-1 first, then wrap to 0..rr_ptr-1.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 2'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_grant_valid && !w_empty[i] && (2'(i) >= r_rr_ptr)) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = 2'(i);
            end else begin
                w_grant_idx   = w_grant_idx;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_grant_valid && !w_empty[i] && (2'(i) < r_rr_ptr)) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = 2'(i);
            end else begin
                w_grant_idx   = w_grant_idx;
            end
        end
    end

    assign w_win_entry = w_head[w_grant_idx];

    // Broadcast registers and round-robin pointer.
    always_ff @(posedge clk_in) begin
        if (w_flush) begin
            r_rr_ptr     <= 2'd0;
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= {ROB_ID_W{1'b0}};
            r_cdb_val    <= 32'd0;
            r_cdb_src    <= CDB_SRC_ALU;
        end else if (rdy_in) begin
            if (w_grant_valid) begin
                r_cdb_valid  <= 1'b1;
                r_cdb_rob_id <= w_win_entry[ENTRY_W-1 -: ROB_ID_W];
                r_cdb_val    <= w_win_entry[31:0];
                r_cdb_src    <= w_grant_idx;
                r_rr_ptr     <= rr_next(w_grant_idx, NUM_SRC);
            end else begin
                // Idle bus: clear the payload, keep the last source and pointer.
                r_cdb_valid  <= 1'b0;
                r_cdb_rob_id <= {ROB_ID_W{1'b0}};
                r_cdb_val    <= 32'd0;
            end
        end
    end

    assign cdb_valid  = r_cdb_valid;
    assign cdb_rob_id = r_cdb_rob_id;
    assign cdb_val    = r_cdb_val;
    assign cdb_src    = r_cdb_src;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among result producers (ALU, LSB, branch unit).
- Each producer pushes {ROB id, value} into its own small FIFO. A round-robin scheduler grants one FIFO per cycle and drives a registered broadcast.
- The broadcast is consumed by the reservation station, the LSB and the ROB for dependency wake-up and commit marking.
- The block is flushed on branch mispredict.

Parameters:
- NUM_SRC, 3, number of producers; index 0=ALU, 1=LSB, 2=BRU.
- FIFO_DEPTH, 2, entries per producer FIFO; power of two, at least 2.
- ROB_ID_W, 5, ROB id width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, synchronous, active-high.
- rdy_in  input  1  global enable; when low, all state holds.
- clear_flag  input  1  mispredict flush; same effect as reset.
- src_valid  input  NUM_SRC  per-producer push request.
- src_rob_id  input  NUM_SRC*ROB_ID_W  flattened ROB ids; source i occupies bits [i*ROB_ID_W +: ROB_ID_W].
- src_val  input  NUM_SRC*32  flattened result values; source i occupies bits [i*32 +: 32].
- src_ready  output  NUM_SRC  FIFO i can accept a push this cycle.
- cdb_valid  output  1  broadcast valid; a one-cycle pulse per result.
- cdb_rob_id  output  ROB_ID_W  broadcast ROB id.
- cdb_val  output  32  broadcast value.
- cdb_src  output  2  index of the granted producer (debug/perf).

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on rst_in.
- On rst_in or clear_flag, at the next edge:
  - all FIFOs are emptied (rd/wr pointers and counts set to 0);
  - rr_ptr is set to 0;
  - cdb_valid, cdb_rob_id, cdb_val and cdb_src are set to 0.
  - clear_flag is sampled even when rdy_in is low; rst_in has priority.
- src_ready[i] is combinational: count[i] < FIFO_DEPTH.
  - A push to a full FIFO is ignored. The producer must hold the result until src_ready is high.
  - There is no full-FIFO bypass: a simultaneous pop does not free space in the same cycle.
- Push: if rdy_in and src_valid[i] and src_ready[i], then at the edge the entry is written at wr_ptr[i], wr_ptr[i] increments (wrapping modulo FIFO_DEPTH), and count[i] increments.
- Grant: combinational over the non-empty FIFOs.
  - Search starts at index rr_ptr and wraps through NUM_SRC-1 back to 0.
  - The first non-empty FIFO wins.
  - An entry pushed in cycle t is eligible for grant in cycle t+1 or later.
- Pop/broadcast: if rdy_in and any FIFO is non-empty, then at the edge:
  - cdb_valid<=1; cdb_rob_id/cdb_val<=head entry of the winner; cdb_src<=winner;
  - rd_ptr of the winner increments (wrapping) and its count decrements;
  - rr_ptr <= winner+1 (mod NUM_SRC).
- If no FIFO is non-empty while rdy_in is high: cdb_valid<=0, cdb_rob_id<=0, cdb_val<=0, cdb_src holds, rr_ptr holds.
- Same-FIFO push and pop in one cycle: both apply and count is unchanged. The pop takes the old head; the push goes to the tail.
- Latency: with the bus idle, a push accepted at edge E is broadcast at edge E+1, so cdb_valid is high in the cycle after E+1.
- Throughput: one result per cycle total.
  - Fairness: no non-empty source waits more than NUM_SRC-1 grants.
  - Each source's results are broadcast in push order; there is no ordering across sources.
- rdy_in low: no push, no pop, all registers hold, and cdb_valid holds its last value. Consumers gate on rdy_in.
- A single source never pushes a given ROB id twice before it is broadcast. The arbiter does not check for duplicates.

Decomposition:
- Shared package/const.v:
  - ROB_ID_W;
  - CDB source index constants (CDB_SRC_ALU=0, CDB_SRC_LSB=1, CDB_SRC_BRU=2);
  - the CDB entry layout (rob_id concatenated with val; 37 bits).
- Sub-module cdb_src_fifo, instantiated NUM_SRC times in a generate loop:
  - parameterised by depth and entry width;
  - contains pointers, count, push/pop and flush, and exports empty/full/head.
- The top level holds the round-robin grant logic and the output registers.

Test Plan:
- Reset/flush: fill all FIFOs, then pulse clear_flag with rdy_in=0 → next cycle all src_ready=1 and cdb_valid=0. Then push ALU {3, 0x11} → broadcast {3, 0x11} with cdb_src=0, confirming rr_ptr was reset to 0.
- Single source latency: push LSB {7, 0xDEADBEEF} at edge E → cdb_valid=1, rob_id=7, val=0xDEADBEEF, src=1 after E+1; one cycle later cdb_valid=0.
- Round-robin: push to all three sources in the same cycle ({1,A}, {2,B}, {3,C}) → broadcast order is src 0,1,2 on consecutive cycles. Then repeat with rr_ptr=1 → order 1,2,0.
- Backpressure: hold ALU valid for 4 cycles while LSB and BRU are continuously busy → ALU src_ready drops to 0 once count=2. No entry is lost or duplicated, and ALU ids come out in push order.
- Stall: set rdy_in=0 for 3 cycles while FIFOs are non-empty → outputs and counts are frozen. On rdy_in=1, broadcast resumes at the same winner.
- Concurrent push+pop on the same FIFO at count=1 → count stays 1 and values come out FIFO-ordered.
